// File: rtl/sm_mem_arbiter.sv
// ---------------------------------------------------------------------------
// sm_mem_arbiter
//
// Shares one fixed-latency synchronous memory between the schoolMIPS
// instruction-fetch port (i_*) and the load/store data port (d_*).
// Each access walks IDLE -> ISSUE -> WAIT -> DONE, and the winning port
// gets a one-cycle ack in DONE.
//
// Handshake: a port raises *_req with its address (and for the data port
// d_we/d_wdata) and holds them until its *_ack pulse. Request fields are
// sampled once, on the IDLE clock edge that starts the access; later
// changes are ignored. *_rdata is valid in the ack cycle. A req still
// high after its ack is treated as a fresh request.
//
// Configuration macro:
//   SM_ARB_ROUND_ROBIN_EN  - defined: on a conflict, grant the port that
//                            did not win last time (first conflict after
//                            reset goes to D).
//                            undefined: data port always wins a conflict.
//
// Parameters:
//   ADDR_WIDTH  - word address width on all ports
//   WAIT_STATES - memory read latency after the m_en cycle, 1..15
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_req/i_addr        instruction read request and address
//   i_ack/i_rdata       instruction completion pulse and read data
//   d_req/d_we/d_addr/d_wdata   data request, write flag, address, wdata
//   d_ack/d_rdata       data completion pulse and read data
//   m_en/m_we/m_addr/m_wdata    memory strobe, write enable, addr, wdata
//   m_rdata             memory read data (WAIT_STATES cycles after m_en)
//   busy                high whenever an access is in flight
//   dbgState            current FSM state for observation
// ---------------------------------------------------------------------------
module sm_mem_arbiter #(
   parameter int ADDR_WIDTH  = 32,
   parameter int WAIT_STATES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   // instruction port
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  i_ack,
   output logic [31:0]           i_rdata,
   // data port
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [31:0]           d_wdata,
   output logic                  d_ack,
   output logic [31:0]           d_rdata,
   // unified memory
   output logic                  m_en,
   output logic                  m_we,
   output logic [ADDR_WIDTH-1:0] m_addr,
   output logic [31:0]           m_wdata,
   input  logic [31:0]           m_rdata,
   // status
   output logic                  busy,
   output logic [1:0]            dbgState
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } arbState_t;

   arbState_t             state;
   arbState_t             nextState;

   logic                  grantD;     // 1: current access belongs to D port
   logic                  weLatch;    // latched write flag of current access
   logic [ADDR_WIDTH-1:0] addrReg;    // drives m_addr, holds between accesses
   logic [31:0]           wdataReg;   // drives m_wdata, holds between accesses
   logic [3:0]            waitCnt;
   logic [31:0]           rdataReg;
   logic                  pickD;      // arbitration result for this IDLE cycle

`ifdef SM_ARB_ROUND_ROBIN_EN
   logic                  lastGrantD; // port that completed the previous access
`endif

   // ------------------------------------------------------------------
   // Arbitration. Only consulted in IDLE; a lone requester always wins.
   // ------------------------------------------------------------------
   always_comb begin
      pickD = 1'b0;
`ifdef SM_ARB_ROUND_ROBIN_EN
      // On a conflict the port that did not win last time goes first.
      pickD = d_req & (~i_req | ~lastGrantD);
`else
      pickD = d_req;
`endif
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= nextState;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      nextState = state;
      case (state)
         S_IDLE: begin
            if (i_req | d_req) begin
               nextState = S_ISSUE;
            end
         end
         S_ISSUE: begin
            nextState = S_WAIT;
         end
         S_WAIT: begin
            // Counter reaches zero exactly WAIT_STATES cycles after ISSUE,
            // which is the cycle m_rdata is valid.
            if (waitCnt == 4'd0) begin
               nextState = S_DONE;
            end
         end
         S_DONE: begin
            nextState = S_IDLE;
         end
         default: begin
            nextState = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Request latches, wait counter and read-data capture
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grantD   <= 1'b0;
         weLatch  <= 1'b0;
         addrReg  <= '0;
         wdataReg <= '0;
         waitCnt  <= 4'd0;
         rdataReg <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_req | d_req) begin
                  grantD  <= pickD;
                  weLatch <= pickD & d_we;
                  addrReg <= pickD ? d_addr : i_addr;
                  // Instruction fetches never write, so m_wdata keeps the
                  // last data-port value for them.
                  if (pickD) begin
                     wdataReg <= d_wdata;
                  end
               end
            end
            S_ISSUE: begin
               waitCnt <= 4'(WAIT_STATES - 1);
            end
            S_WAIT: begin
               if (waitCnt == 4'd0) begin
                  if (!weLatch) begin
                     rdataReg <= m_rdata;
                  end
               end else begin
                  waitCnt <= waitCnt - 4'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef SM_ARB_ROUND_ROBIN_EN
   // Fairness memory: updated only when an access actually completes, so
   // an access abandoned by reset does not count as a win.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lastGrantD <= 1'b0;
      end else if (state == S_DONE) begin
         lastGrantD <= grantD;
      end
   end
`endif

   // ------------------------------------------------------------------
   // Outputs: decoded from state and latched values only, so no request
   // input reaches an output combinationally.
   // ------------------------------------------------------------------
   assign m_en     = (state == S_ISSUE);
   assign m_we     = (state == S_ISSUE) & weLatch;
   assign m_addr   = addrReg;
   assign m_wdata  = wdataReg;
   assign i_ack    = (state == S_DONE) & ~grantD;
   assign d_ack    = (state == S_DONE) &  grantD;
   assign i_rdata  = rdataReg;
   assign d_rdata  = rdataReg;
   assign busy     = (state != S_IDLE);
   assign dbgState = state;

   // Latency outside 1..15 cannot be represented by the 4-bit counter.
   always_ff @(posedge clk) begin : paramCheck
      assert (WAIT_STATES >= 1 && WAIT_STATES <= 15)
         else $error("sm_mem_arbiter: WAIT_STATES=%0d outside 1..15", WAIT_STATES);
   end

endmodule

// File: tb/tb_sm_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sm_mem_arbiter
//
// Two arbiter instances: port index 0 uses WAIT_STATES=1, index 1 uses
// WAIT_STATES=3. Each has its own memory with the matching read latency.
// A transaction-level model tracks, per instance, when an access started
// and derives every output from the latency rules. A compare process
// checks all outputs against that model on every falling edge. Directed
// sequences add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_sm_mem_arbiter;

   localparam int AW  = 32;
   localparam int WS0 = 1;
   localparam int WS1 = 3;

`ifdef SM_ARB_ROUND_ROBIN_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   localparam byte CH_I = 8'd73;  // "I"
   localparam byte CH_D = 8'd68;  // "D"

   // ------------------------------------------------------------------
   // Clock / reset
   // ------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // DUT signals, one element per instance
   // ------------------------------------------------------------------
   logic          iReq   [2];
   logic [AW-1:0] iAddr  [2];
   logic          iAck   [2];
   logic [31:0]   iRdata [2];
   logic          dReq   [2];
   logic          dWe    [2];
   logic [AW-1:0] dAddr  [2];
   logic [31:0]   dWdata [2];
   logic          dAck   [2];
   logic [31:0]   dRdata [2];
   logic          mEn    [2];
   logic          mWe    [2];
   logic [AW-1:0] mAddr  [2];
   logic [31:0]   mWdata [2];
   logic [31:0]   mRdata [2];
   logic          busy   [2];
   logic [1:0]    dbgState [2];

   int checks = 0;
   int errors = 0;

   function automatic int wsOf(input int p);
      return (p == 0) ? WS0 : WS1;
   endfunction

   // Power-up memory contents (identical for both instances).
   function automatic logic [31:0] memInit(input logic [7:0] a);
      return (a == 8'h10) ? 32'hDEADBEEF : (32'hC0DE0000 | {24'd0, a});
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // DUTs and their memories
   // ------------------------------------------------------------------
   for (genvar g = 0; g < 2; g++) begin : gInst
      localparam int WS = (g == 0) ? WS0 : WS1;

      sm_mem_arbiter #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
         .clk      (clk),
         .rst      (rst),
         .i_req    (iReq[g]),
         .i_addr   (iAddr[g]),
         .i_ack    (iAck[g]),
         .i_rdata  (iRdata[g]),
         .d_req    (dReq[g]),
         .d_we     (dWe[g]),
         .d_addr   (dAddr[g]),
         .d_wdata  (dWdata[g]),
         .d_ack    (dAck[g]),
         .d_rdata  (dRdata[g]),
         .m_en     (mEn[g]),
         .m_we     (mWe[g]),
         .m_addr   (mAddr[g]),
         .m_wdata  (mWdata[g]),
         .m_rdata  (mRdata[g]),
         .busy     (busy[g]),
         .dbgState (dbgState[g])
      );

      // Memory with a WS-deep read pipeline; garbage outside valid slots
      // so an early or late capture shows up as wrong data.
      logic [31:0] mem  [0:255];
      logic [31:0] pipe [0:15];
      logic        memInited = 1'b0;

      always @(posedge clk or posedge rst) begin
         if (rst) begin
            if (!memInited) begin
               for (int i = 0; i < 256; i++) mem[i] <= memInit(i[7:0]);
               memInited <= 1'b1;
            end
            for (int k = 0; k < 16; k++) pipe[k] <= 32'hA5A5A5A5;
         end else begin
            if (mEn[g] && mWe[g]) mem[mAddr[g][7:0]] <= mWdata[g];
            pipe[0] <= (mEn[g] && !mWe[g]) ? mem[mAddr[g][7:0]] : 32'hA5A5A5A5;
            for (int k = 1; k < 16; k++) pipe[k] <= pipe[k-1];
         end
      end

      assign mRdata[g] = pipe[WS-1];
   end

   // ------------------------------------------------------------------
   // Transaction-level model. An access granted at the edge that ends
   // cycle n has start = n+1: m_en during cycle start, read data captured
   // at the end of cycle start+WS, ack during cycle start+WS+1.
   // ------------------------------------------------------------------
   int            cyc = 0;
   logic          mdActive [2];
   int            mdStart  [2];
   logic          mdIsD    [2];
   logic          mdWe     [2];
   logic          mdLastD  [2];
   logic [AW-1:0] mdAddr   [2];
   logic [31:0]   mdWdata  [2];
   logic [31:0]   mdRd     [2];
   logic [31:0]   refMem   [0:511];
   logic          refInited = 1'b0;
   byte           modelSeq [$];
   byte           ackLog   [$];

   function automatic logic arbD(input logic iR, input logic dR, input logic lastD);
      if (iR && dR) return RR_EN ? !lastD : 1'b1;
      return dR;
   endfunction

   always @(posedge clk or posedge rst) begin : model
      if (rst) begin
         if (!refInited) begin
            for (int i = 0; i < 512; i++) refMem[i] <= memInit(i[7:0]);
            refInited <= 1'b1;
         end
         for (int p = 0; p < 2; p++) begin
            mdActive[p] <= 1'b0;
            mdIsD[p]    <= 1'b0;
            mdWe[p]     <= 1'b0;
            mdLastD[p]  <= 1'b0;
            mdAddr[p]   <= '0;
            mdRd[p]     <= 32'd0;
         end
      end else begin
         cyc <= cyc + 1;
         for (int p = 0; p < 2; p++) begin
            if (mdActive[p]) begin
               if (cyc == mdStart[p] && mdWe[p])
                  refMem[p*256 + int'(mdAddr[p][7:0])] <= mdWdata[p];
               if (cyc == mdStart[p] + wsOf(p) && !mdWe[p])
                  mdRd[p] <= refMem[p*256 + int'(mdAddr[p][7:0])];
               if (cyc == mdStart[p] + wsOf(p) + 1) begin
                  mdActive[p] <= 1'b0;
                  mdLastD[p]  <= mdIsD[p];
               end
            end else if (iReq[p] || dReq[p]) begin
               mdActive[p] <= 1'b1;
               mdStart[p]  <= cyc + 1;
               mdIsD[p]    <= arbD(iReq[p], dReq[p], mdLastD[p]);
               mdWe[p]     <= arbD(iReq[p], dReq[p], mdLastD[p]) & dWe[p];
               mdAddr[p]   <= arbD(iReq[p], dReq[p], mdLastD[p]) ? dAddr[p] : iAddr[p];
               mdWdata[p]  <= dWdata[p];
               if (p == 0) modelSeq.push_back(arbD(iReq[p], dReq[p], mdLastD[p]) ? CH_D : CH_I);
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Scoreboard compare, every falling edge
   // ------------------------------------------------------------------
   task automatic cmpPort(input int p);
      logic en;
      logic ackNow;
      en     = mdActive[p] && (cyc == mdStart[p]);
      ackNow = mdActive[p] && (cyc == mdStart[p] + wsOf(p) + 1);
      chk($sformatf("p%0d_m_en", p),    mEn[p],    en);
      chk($sformatf("p%0d_m_we", p),    mWe[p],    en & mdWe[p]);
      chk($sformatf("p%0d_m_addr", p),  mAddr[p],  mdAddr[p]);
      if (en && mdWe[p]) chk($sformatf("p%0d_m_wdata", p), mWdata[p], mdWdata[p]);
      chk($sformatf("p%0d_i_ack", p),   iAck[p],   ackNow & ~mdIsD[p]);
      chk($sformatf("p%0d_d_ack", p),   dAck[p],   ackNow & mdIsD[p]);
      chk($sformatf("p%0d_i_rdata", p), iRdata[p], mdRd[p]);
      chk($sformatf("p%0d_d_rdata", p), dRdata[p], mdRd[p]);
      chk($sformatf("p%0d_busy", p),    busy[p],   mdActive[p]);
   endtask

   always @(negedge clk) begin : compare
      cmpPort(0);
      cmpPort(1);
      if (iAck[0]) ackLog.push_back(CH_I);
      if (dAck[0]) ackLog.push_back(CH_D);
   end

   // ------------------------------------------------------------------
   // Directed stimulus with literal expectations
   // ------------------------------------------------------------------
   string expSeq;
   int    ackBase;
   int    mdlBase;

   initial begin
      for (int p = 0; p < 2; p++) begin
         iReq[p] = 1'b0; iAddr[p] = '0;
         dReq[p] = 1'b0; dWe[p] = 1'b0; dAddr[p] = '0; dWdata[p] = 32'd0;
      end
      expSeq = RR_EN ? "DIDI" : "DDDD";
      rst = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy[0], 0);
      chk("rst_m_en", mEn[0], 0);
      chk("rst_i_ack", iAck[0], 0);
      chk("rst_m_addr", mAddr[0], 0);
      chk("rst_rdata", iRdata[0], 0);
      #2 rst = 1'b0;

      // Instruction read of 0x10, WAIT_STATES=1
      @(negedge clk); #2;
      iReq[0] = 1'b1; iAddr[0] = 32'h10;                  // cycle T
      @(negedge clk);                                      // T+1
      chk("t2_m_en", mEn[0], 1);
      chk("t2_m_we", mWe[0], 0);
      chk("t2_m_addr", mAddr[0], 32'h10);
      @(negedge clk);                                      // T+2
      chk("t2_m_en_once", mEn[0], 0);
      chk("t2_i_ack_early", iAck[0], 0);
      @(negedge clk);                                      // T+3
      chk("t2_i_ack", iAck[0], 1);
      chk("t2_i_rdata", iRdata[0], 32'hDEADBEEF);
      chk("t2_d_ack", dAck[0], 0);
      chk("t2_model_rd", mdRd[0], 32'hDEADBEEF);
      #2 iReq[0] = 1'b0;
      @(negedge clk);                                      // T+4
      chk("t2_i_ack_once", iAck[0], 0);
      chk("t2_idle", busy[0], 0);

      // Data write 0x20 <- 0x12345678, then req held -> read back
      #2;
      dReq[0] = 1'b1; dWe[0] = 1'b1; dAddr[0] = 32'h20; dWdata[0] = 32'h12345678;
      @(negedge clk);                                      // T+1
      chk("t3_m_en", mEn[0], 1);
      chk("t3_m_we", mWe[0], 1);
      chk("t3_m_addr", mAddr[0], 32'h20);
      chk("t3_m_wdata", mWdata[0], 32'h12345678);
      @(negedge clk);
      @(negedge clk);                                      // T+3
      chk("t3_d_ack", dAck[0], 1);
      chk("t3_i_ack", iAck[0], 0);
      #2 dWe[0] = 1'b0;                                    // still requesting: read
      @(negedge clk);                                      // T+4 idle, sampled
      chk("t3_gap_idle", busy[0], 0);
      @(negedge clk);                                      // T+5
      chk("t3_rd_m_en", mEn[0], 1);
      chk("t3_rd_m_we", mWe[0], 0);
      @(negedge clk);
      @(negedge clk);                                      // T+7
      chk("t3_rd_ack", dAck[0], 1);
      chk("t3_rd_data", dRdata[0], 32'h12345678);
      #2 dReq[0] = 1'b0;

      // Reset mid-transaction, then a normal request
      @(negedge clk); #2;
      iReq[0] = 1'b1; iAddr[0] = 32'h44;
      @(negedge clk);                                      // ISSUE
      @(negedge clk); #2;                                  // WAIT
      rst = 1'b1;
      #1;
      chk("t1_busy", busy[0], 0);
      chk("t1_m_en", mEn[0], 0);
      chk("t1_i_ack", iAck[0], 0);
      chk("t1_rdata", iRdata[0], 0);
      iReq[0] = 1'b0;
      @(negedge clk);
      @(negedge clk); #2;
      rst = 1'b0;
      iReq[0] = 1'b1; iAddr[0] = 32'h44;                  // cycle T
      @(negedge clk);
      chk("t1_post_m_addr", mAddr[0], 32'h44);
      @(negedge clk);
      @(negedge clk);                                      // T+3
      chk("t1_post_i_ack", iAck[0], 1);
      chk("t1_post_rdata", iRdata[0], 32'hC0DE0044);
      #2 iReq[0] = 1'b0;

      // Both request: D first, then I through an IDLE cycle
      @(negedge clk); #2;
      iReq[0] = 1'b1; iAddr[0] = 32'h30;
      dReq[0] = 1'b1; dWe[0] = 1'b0; dAddr[0] = 32'h40;   // cycle T
      @(negedge clk);                                      // T+1
      chk("t4_first_addr", mAddr[0], 32'h40);
      @(negedge clk);
      @(negedge clk);                                      // T+3
      chk("t4_d_ack", dAck[0], 1);
      chk("t4_d_rdata", dRdata[0], 32'hC0DE0040);
      chk("t4_i_ack_wait", iAck[0], 0);
      #2 dReq[0] = 1'b0;
      @(negedge clk);                                      // T+4
      chk("t4_gap_m_en", mEn[0], 0);
      chk("t4_gap_busy", busy[0], 0);
      @(negedge clk);                                      // T+5
      chk("t4_i_m_en", mEn[0], 1);
      chk("t4_i_m_addr", mAddr[0], 32'h30);
      @(negedge clk);
      @(negedge clk);                                      // T+7
      chk("t4_i_ack", iAck[0], 1);
      chk("t4_i_rdata", iRdata[0], 32'hC0DE0030);
      #2 iReq[0] = 1'b0;

      // Both held for four transactions
      @(negedge clk); #2;
      ackBase = ackLog.size();
      mdlBase = modelSeq.size();
      iReq[0] = 1'b1; iAddr[0] = 32'h11;
      dReq[0] = 1'b1; dWe[0] = 1'b0; dAddr[0] = 32'h22;
      for (int k = 0; k < 60 && ackLog.size() < ackBase + 4; k++) begin
         @(negedge clk); #1;
      end
      iReq[0] = 1'b0; dReq[0] = 1'b0;
      chk("t5_ack_count", ackLog.size() - ackBase, 4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t5_ack_%0d", k),
             (ackBase + k < ackLog.size()) ? ackLog[ackBase + k] : 8'd0, expSeq[k]);
         chk($sformatf("t5_model_%0d", k),
             (mdlBase + k < modelSeq.size()) ? modelSeq[mdlBase + k] : 8'd0, expSeq[k]);
      end

      // WAIT_STATES=3: reset during WAIT, then a fresh fetch
      @(negedge clk); #2;
      iReq[1] = 1'b1; iAddr[1] = 32'h50;
      @(negedge clk);
      chk("t6_m_en", mEn[1], 1);
      @(negedge clk); #2;                                  // WAIT
      rst = 1'b1;
      #1;
      chk("t6_busy", busy[1], 0);
      chk("t6_m_en_rst", mEn[1], 0);
      chk("t6_i_ack_rst", iAck[1], 0);
      iReq[1] = 1'b0;
      @(negedge clk); #2;
      rst = 1'b0;
      iReq[1] = 1'b1; iAddr[1] = 32'h60;                  // cycle T
      @(negedge clk);                                      // T+1
      chk("t6_post_m_en", mEn[1], 1);
      chk("t6_post_m_addr", mAddr[1], 32'h60);
      repeat (3) @(negedge clk);                           // T+4
      chk("t6_i_ack_early", iAck[1], 0);
      @(negedge clk);                                      // T+5
      chk("t6_i_ack", iAck[1], 1);
      chk("t6_i_rdata", iRdata[1], 32'hC0DE0060);
      #2 iReq[1] = 1'b0;

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
